// File: rtl/port_rd_ctl_pkg.sv
// Shared definitions for the per-port read engine: sizes, FSM states,
// WRR credit type and the arbitration helper functions.
package port_rd_ctl_pkg;

    localparam int num_of_priority = 8;
    localparam int address_width   = 12;
    localparam int data_width      = 16;
    localparam int len_width       = 10;
    localparam int credit_width    = $clog2(num_of_priority + 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    typedef logic [credit_width-1:0] credit_t;

    // Queue p earns p+1 grants per WRR round.
    function automatic credit_t wrr_weight(input int p);
        return credit_t'(p + 1);
    endfunction

    function automatic logic [num_of_priority-1:0] highest_onehot(
        input logic [num_of_priority-1:0] req
    );
        logic [num_of_priority-1:0] sel;
        sel = '0;
        for (int p = 0; p < num_of_priority; p++) begin
            if (req[p]) begin
                sel    = '0;
                sel[p] = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/port_rd_ctl_prio_arbiter.sv
// Priority queue arbiter: strict priority or weighted round-robin with
// per-queue credits that refill together once every ready queue is spent.
module prio_arbiter
    import port_rd_ctl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [num_of_priority-1:0] q_ready,
    input  logic                       sp0_wrr1,
    input  logic                       arb_en,
    output logic [num_of_priority-1:0] grant
);

    credit_t                    credit [num_of_priority];
    logic [num_of_priority-1:0] eligible;
    logic [num_of_priority-1:0] sp_grant;
    logic [num_of_priority-1:0] wrr_grant;
    logic                       reload;

    always_comb begin
        eligible = '0;
        for (int p = 0; p < num_of_priority; p++) begin
            eligible[p] = q_ready[p] && (credit[p] != '0);
        end
        // All ready queues out of credit: refill, and the refilled values
        // make every ready queue eligible, so plain priority picks the winner.
        reload    = (eligible == '0) && (q_ready != '0);
        sp_grant  = highest_onehot(q_ready);
        wrr_grant = reload ? sp_grant : highest_onehot(eligible);
        grant     = sp0_wrr1 ? wrr_grant : sp_grant;
    end

    // Credits only move on WRR grants; SP grants leave them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < num_of_priority; p++) begin
                credit[p] <= wrr_weight(p);
            end
        end else if (arb_en && sp0_wrr1) begin
            for (int p = 0; p < num_of_priority; p++) begin
                if (reload) begin
                    credit[p] <= wrr_weight(p) - credit_t'(wrr_grant[p]);
                end else if (wrr_grant[p]) begin
                    credit[p] <= credit[p] - credit_t'(1);
                end
            end
        end
    end

endmodule

// File: rtl/port_rd_ctl.sv
// Per-port read engine: grants one priority queue, pops its descriptor and
// streams the packet from SRAM with sop/eop framing aligned to read latency.
module port_rd_ctl
    import port_rd_ctl_pkg::*;
(
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     sp0_wrr1,
    input  logic [num_of_priority-1:0]               q_ready,
    input  logic [num_of_priority*address_width-1:0] desc_addr,
    input  logic [num_of_priority*len_width-1:0]     desc_len,
    output logic [num_of_priority-1:0]               desc_pop,
    output logic                                     sram_rd_en,
    output logic [address_width-1:0]                 sram_rd_addr,
    input  logic [data_width-1:0]                    sram_rdata,
    output logic                                     rd_sop,
    output logic                                     rd_eop,
    output logic                                     rd_vld,
    output logic [data_width-1:0]                    rd_data
);

    state_t                     state;
    state_t                     state_next;
    logic [address_width-1:0]   addr_cnt;
    logic [len_width-1:0]       words_left;
    logic                       first_word;
    logic                       last_word;
    logic                       arb_en;
    logic [num_of_priority-1:0] grant;
    logic [address_width-1:0]   sel_addr;
    logic [len_width-1:0]       sel_len;

    prio_arbiter u_arb (
        .clk      (clk),
        .rst      (rst),
        .q_ready  (q_ready),
        .sp0_wrr1 (sp0_wrr1),
        .arb_en   (arb_en),
        .grant    (grant)
    );

    // rst gates the grant so desc_pop drops the instant reset is asserted.
    always_comb begin
        arb_en   = (state == IDLE) && (q_ready != '0) && !rst;
        sel_addr = '0;
        sel_len  = '0;
        for (int p = 0; p < num_of_priority; p++) begin
            if (grant[p]) begin
                sel_addr = desc_addr[p*address_width +: address_width];
                sel_len  = desc_len[p*len_width +: len_width];
            end
        end
        last_word  = (state == READ) && (words_left == len_width'(1));
        state_next = state;
        case (state)
            IDLE:    if (arb_en) state_next = READ;
            READ:    if (words_left <= len_width'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        desc_pop     = arb_en ? grant : '0;
        sram_rd_en   = (state == READ);
        sram_rd_addr = addr_cnt;
        rd_data      = rd_vld ? sram_rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A zero-length descriptor is read as a single word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt   <= '0;
            words_left <= '0;
            first_word <= 1'b0;
        end else if (arb_en) begin
            addr_cnt   <= sel_addr;
            words_left <= (sel_len == '0) ? len_width'(1) : sel_len;
            first_word <= 1'b1;
        end else if (state == READ) begin
            addr_cnt   <= addr_cnt + address_width'(1);
            words_left <= words_left - len_width'(1);
            first_word <= 1'b0;
        end
    end

    // Framing is delayed one cycle to line up with SRAM read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld <= 1'b0;
            rd_sop <= 1'b0;
            rd_eop <= 1'b0;
        end else begin
            rd_vld <= sram_rd_en;
            rd_sop <= sram_rd_en && first_word;
            rd_eop <= last_word;
        end
    end

endmodule
